// File: rtl/syn_fetch_queue_pkg.sv
// Shared core constants and helpers for the instruction fetch queue.
// IM_ADDR_BIT, CORE_INSTR_BIT, FQ_DEPTH and FQ_ENTRY_BIT are the core-wide widths;
// an entry is laid out as {pc, instr, gussed}.
package syn_fetch_queue_pkg;

    localparam int unsigned IM_ADDR_BIT    = 10;
    localparam int unsigned CORE_INSTR_BIT = 32;
    localparam int unsigned FQ_DEPTH       = 4;
    localparam int unsigned FQ_ENTRY_BIT   = IM_ADDR_BIT + CORE_INSTR_BIT + 1;

    // Storage operation applied at the next clock edge
    typedef enum logic [1:0] {
        FQ_HOLD     = 2'b00,
        FQ_PUSH     = 2'b01,
        FQ_POP      = 2'b10,
        FQ_PUSH_POP = 2'b11
    } fq_op_e;

    function automatic fq_op_e fq_op(input logic push, input logic pop);
        fq_op_e op;
        case ({pop, push})
            2'b01:   op = FQ_PUSH;
            2'b10:   op = FQ_POP;
            2'b11:   op = FQ_PUSH_POP;
            default: op = FQ_HOLD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/fq_ring_ram.sv
// Fetch queue storage: DEPTH x WIDTH register array, one synchronous
// write port and one asynchronous read port. Contents are never reset.
module fq_ring_ram #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ADDR_BIT = 2,
    parameter int unsigned WIDTH    = 43
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_BIT-1:0] waddr,
    input  logic [WIDTH-1:0]    wdata,
    input  logic [ADDR_BIT-1:0] raddr,
    output logic [WIDTH-1:0]    rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the incoming entry at the write pointer
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/syn_fetch_queue.sv
// Instruction fetch queue between the PC/IM stage and decode.
// Circular buffer with write/read pointers and an occupancy counter;
// a flush (misprediction) empties it in one cycle. ~in_ready is the PC stall.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (empty-queue pass-through).
module syn_fetch_queue
    import syn_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = FQ_DEPTH,
    parameter int unsigned PTR_BIT   = $clog2(DEPTH),
    parameter int unsigned INSTR_BIT = CORE_INSTR_BIT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IM_ADDR_BIT-1:0] in_pc,
    input  logic [INSTR_BIT-1:0]   in_instr,
    input  logic                   in_gussed,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IM_ADDR_BIT-1:0] out_pc,
    output logic [IM_ADDR_BIT-1:0] out_pc_4,
    output logic [INSTR_BIT-1:0]   out_instr,
    output logic                   out_gussed,
    output logic [PTR_BIT:0]       count
);

    localparam int unsigned    ENTRY_BIT = IM_ADDR_BIT + INSTR_BIT + 1;
    localparam logic [PTR_BIT:0] FULL    = (PTR_BIT + 1)'(DEPTH);

    logic [PTR_BIT-1:0]   wp;
    logic [PTR_BIT-1:0]   rp;
    logic [PTR_BIT:0]     count_q;
    logic                 stored_valid;
    logic                 push;
    logic                 pop;
    logic                 store_wr;
    logic                 store_rd;
    logic [ENTRY_BIT-1:0] wr_data;
    logic [ENTRY_BIT-1:0] rd_data;
    logic [ENTRY_BIT-1:0] head;
    fq_op_e               op;

    assign in_ready     = (count_q != FULL);
    assign stored_valid = (count_q != '0);
    assign push         = en & in_valid & in_ready;
    assign pop          = en & out_valid & out_ready;
    assign wr_data      = {in_pc, in_instr, in_gussed};

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;

    // An empty queue forwards the incoming entry; if decode takes it in the
    // same cycle it never touches storage, so only stored traffic moves pointers.
    assign bypass    = ~stored_valid & in_valid;
    assign out_valid = stored_valid | (bypass & ~flush);
    assign head      = bypass ? wr_data : rd_data;
    assign store_wr  = push & ~(bypass & pop);
    assign store_rd  = pop & stored_valid;
`else
    assign out_valid = stored_valid;
    assign head      = rd_data;
    assign store_wr  = push;
    assign store_rd  = pop;
`endif

    assign {out_pc, out_instr, out_gussed} = head;
    assign out_pc_4 = out_pc + IM_ADDR_BIT'(1);
    assign count    = count_q;

    // Decode the storage operation for this cycle
    always_comb begin
        op = fq_op(store_wr, store_rd);
    end

    // Pointer and occupancy update; rst > flush > push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wp      <= '0;
            rp      <= '0;
            count_q <= '0;
        end else if (en) begin
            if (flush) begin
                wp      <= '0;
                rp      <= '0;
                count_q <= '0;
            end else begin
                case (op)
                    FQ_PUSH: begin
                        wp      <= wp + PTR_BIT'(1);
                        count_q <= count_q + (PTR_BIT + 1)'(1);
                    end
                    FQ_POP: begin
                        rp      <= rp + PTR_BIT'(1);
                        count_q <= count_q - (PTR_BIT + 1)'(1);
                    end
                    FQ_PUSH_POP: begin
                        wp <= wp + PTR_BIT'(1);
                        rp <= rp + PTR_BIT'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    fq_ring_ram #(
        .DEPTH    (DEPTH),
        .ADDR_BIT (PTR_BIT),
        .WIDTH    (ENTRY_BIT)
    ) u_ram (
        .clk   (clk),
        .we    (en & ~rst & ~flush & store_wr),
        .waddr (wp),
        .wdata (wr_data),
        .raddr (rp),
        .rdata (rd_data)
    );

endmodule
